// File: rtl/bist_addr_data_path.sv
// BIST address/data datapath: up/down address counter, background write data,
// two-stage read-compare pipeline and a sticky first-failure record.
module bist_addr_data_path #(
  parameter int DATA_WIDTH = 8,
  parameter int AD_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reset,
  input  logic                  preset,
  input  logic                  en,
  input  logic                  up_down,
  input  logic                  read,
  input  logic                  write,
  input  logic                  data,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [AD_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic                  carry,
  output logic                  is_equal,
  output logic                  cmp_valid,
  output logic                  fail_seen,
  output logic [AD_WIDTH-1:0]   fail_addr
);

  logic [AD_WIDTH-1:0]   cnt;
  logic                  valid1;
  logic [DATA_WIDTH-1:0] exp1;
  logic [AD_WIDTH-1:0]   addr1;
  logic                  cmp_done;
  logic                  mismatch;

  assign mem_addr  = cnt;
  assign mem_wdata = {DATA_WIDTH{data}};
  assign mem_we    = write;
  assign mem_re    = read & ~write;
  assign carry     = en & ((up_down & (cnt == '1)) | (~up_down & (cnt == '0)));

  // A sync reset in the completion cycle drops the in-flight compare entirely.
  assign cmp_done  = valid1 & ~reset;
  assign mismatch  = (mem_rdata != exp1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (reset) begin
      cnt <= '0;
    end else if (preset) begin
      cnt <= '1;
    end else if (en) begin
      cnt <= up_down ? cnt + 1'b1 : cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid1    <= 1'b0;
      exp1      <= '0;
      addr1     <= '0;
      is_equal  <= 1'b1;
      cmp_valid <= 1'b0;
      fail_seen <= 1'b0;
      fail_addr <= '0;
    end else begin
      valid1 <= mem_re & ~reset;
      if (mem_re) begin
        exp1  <= mem_wdata;
        addr1 <= cnt;
      end
      cmp_valid <= cmp_done;
      if (cmp_done) begin
        is_equal <= ~mismatch;
      end
      if (reset) begin
        fail_seen <= 1'b0;
        fail_addr <= '0;
      end else if (cmp_done && mismatch && !fail_seen) begin
        fail_seen <= 1'b1;
        fail_addr <= addr1;
      end
    end
  end

endmodule

// File: tb/tb_bist_addr_data_path.sv
// Bench for bist_addr_data_path: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_bist_addr_data_path;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int AMAX = (1 << AW) - 1;
  localparam int DMAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst, reset, preset, en, up_down, read, write, data;
  logic [DW-1:0] mem_rdata, mem_wdata;
  logic [AW-1:0] mem_addr, fail_addr;
  logic          mem_we, mem_re, carry, is_equal, cmp_valid, fail_seen;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bist_addr_data_path #(.DATA_WIDTH(DW), .AD_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .reset(reset), .preset(preset), .en(en),
    .up_down(up_down), .read(read), .write(write), .data(data),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .carry(carry), .is_equal(is_equal),
    .cmp_valid(cmp_valid), .fail_seen(fail_seen), .fail_addr(fail_addr)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: outstanding reads in a queue tagged with issue cycle.
  typedef struct {
    int cyc;
    int addr;
    int exp;
  } rd_t;

  rd_t pend[$];
  rd_t rd;
  int  cyc_n = 0;
  int  m_addr = 0;
  int  m_fa = 0;
  bit  m_eq = 1'b1;
  bit  m_cv = 1'b0;
  bit  m_fs = 1'b0;
  bit  check_en = 1'b0;

  always @(posedge clk) begin
    int n;
    n = cyc_n;
    cyc_n++;
    if (rst) begin
      m_addr = 0; m_eq = 1'b1; m_cv = 1'b0; m_fs = 1'b0; m_fa = 0;
      pend.delete();
    end else begin
      m_cv = 1'b0;
      if (reset) begin
        pend.delete();
        m_fs = 1'b0;
        m_fa = 0;
      end else begin
        while (pend.size() > 0 && pend[0].cyc < n - 1) void'(pend.pop_front());
        if (pend.size() > 0 && pend[0].cyc == n - 1) begin
          rd = pend.pop_front();
          m_cv = 1'b1;
          m_eq = (int'(mem_rdata) == rd.exp);
          if (!m_eq && !m_fs) begin
            m_fs = 1'b1;
            m_fa = rd.addr;
          end
        end
        if (read && !write) pend.push_back('{n, m_addr, data ? DMAX : 0});
      end
      if (reset)       m_addr = 0;
      else if (preset) m_addr = AMAX;
      else if (en)     m_addr = up_down ? (m_addr + 1) % (AMAX + 1)
                                        : (m_addr + AMAX) % (AMAX + 1);
    end
  end

  always @(negedge clk) begin
    if (check_en && !rst) begin
      chk("mem_addr",  int'(mem_addr),  m_addr);
      chk("mem_wdata", int'(mem_wdata), data ? DMAX : 0);
      chk("mem_we",    int'(mem_we),    int'(write));
      chk("mem_re",    int'(mem_re),    int'(read && !write));
      chk("carry",     int'(carry),
          int'(en && ((up_down && m_addr == AMAX) || (!up_down && m_addr == 0))));
      chk("is_equal",  int'(is_equal),  int'(m_eq));
      chk("cmp_valid", int'(cmp_valid), int'(m_cv));
      chk("fail_seen", int'(fail_seen), int'(m_fs));
      chk("fail_addr", int'(fail_addr), m_fa);
    end
  end

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic nedge;
    @(negedge clk);
  endtask

  initial begin
    bit prev_rd;
    bit prev_d;
    rst = 1'b1; reset = 1'b0; preset = 1'b0; en = 1'b0; up_down = 1'b0;
    read = 1'b0; write = 1'b0; data = 1'b0; mem_rdata = '0;
    nxt; nxt;
    rst = 1'b0;
    check_en = 1'b1;

    // Idle after reset
    for (int i = 0; i < 3; i++) begin
      nedge;
      chk("idle_addr", int'(mem_addr), 0);
      chk("idle_eq",   int'(is_equal), 1);
      chk("idle_cv",   int'(cmp_valid), 0);
      chk("idle_fs",   int'(fail_seen), 0);
      nxt;
    end

    // Up count with wrap, then preset and down count
    reset = 1'b1; nxt; reset = 1'b0;
    en = 1'b1; up_down = 1'b1;
    for (int i = 0; i < 17; i++) begin
      nedge;
      chk("up_addr",  int'(mem_addr), i % 16);
      chk("up_carry", int'(carry), int'(i == 15));
      nxt;
    end
    en = 1'b0; preset = 1'b1; nxt; preset = 1'b0;
    en = 1'b1; up_down = 1'b0;
    for (int i = 0; i < 16; i++) begin
      nedge;
      chk("dn_addr",  int'(mem_addr), 15 - i);
      chk("dn_carry", int'(carry), int'(i == 15));
      nxt;
    end
    en = 1'b0;

    // Write then matching read at address 3
    reset = 1'b1; nxt; reset = 1'b0;
    en = 1'b1; up_down = 1'b1; nxt; nxt; nxt; en = 1'b0;
    write = 1'b1; data = 1'b1;
    nedge;
    chk("wr_addr",  int'(mem_addr), 3);
    chk("wr_wdata", int'(mem_wdata), 8'hFF);
    chk("wr_we",    int'(mem_we), 1);
    chk("wr_re",    int'(mem_re), 0);
    nxt; write = 1'b0; read = 1'b1;
    nxt; read = 1'b0; mem_rdata = 8'hFF;
    nxt;
    nedge;
    chk("rd3_cv", int'(cmp_valid), 1);
    chk("rd3_eq", int'(is_equal), 1);
    chk("rd3_fs", int'(fail_seen), 0);
    nxt;

    // Back-to-back reads at 5, 6, 7 returning 00, 04, 10
    en = 1'b1; up_down = 1'b1; nxt; nxt;
    read = 1'b1; data = 1'b0;
    nedge; chk("b2b_addr", int'(mem_addr), 5);
    nxt; mem_rdata = 8'h00;
    nxt; mem_rdata = 8'h04;
    nedge; chk("b2b_cv0", int'(cmp_valid), 1); chk("b2b_eq0", int'(is_equal), 1);
    nxt; read = 1'b0; en = 1'b0; mem_rdata = 8'h10;
    nedge; chk("b2b_cv1", int'(cmp_valid), 1); chk("b2b_eq1", int'(is_equal), 0);
    chk("b2b_fs1", int'(fail_seen), 1); chk("b2b_fa1", int'(fail_addr), 6);
    nxt;
    nedge; chk("b2b_cv2", int'(cmp_valid), 1); chk("b2b_eq2", int'(is_equal), 0);
    chk("b2b_fa2", int'(fail_addr), 6);
    nxt;
    nedge; chk("b2b_cv3", int'(cmp_valid), 0); chk("b2b_fa3", int'(fail_addr), 6);

    // Read and write together, then preset with en
    nxt; read = 1'b1; write = 1'b1;
    nedge; chk("rw_re", int'(mem_re), 0); chk("rw_we", int'(mem_we), 1);
    nxt; read = 1'b0; write = 1'b0;
    nxt;
    nedge; chk("rw_cv", int'(cmp_valid), 0);
    nxt; preset = 1'b1; en = 1'b1; up_down = 1'b1;
    nxt; preset = 1'b0; en = 1'b0;
    nedge; chk("pre_addr", int'(mem_addr), AMAX);

    // Read followed by sync reset, then by async rst
    nxt; read = 1'b1; data = 1'b1; en = 1'b1;
    nxt; read = 1'b0; en = 1'b0; reset = 1'b1; mem_rdata = 8'h00;
    nxt; reset = 1'b0;
    nedge; chk("srst_cv", int'(cmp_valid), 0); chk("srst_fs", int'(fail_seen), 0);
    chk("srst_addr", int'(mem_addr), 0);
    nxt; read = 1'b1; data = 1'b1; en = 1'b1;
    nxt; read = 1'b0; en = 1'b0; rst = 1'b1; mem_rdata = 8'h00;
    nxt; rst = 1'b0;
    nedge; chk("arst_cv", int'(cmp_valid), 0); chk("arst_fs", int'(fail_seen), 0);
    chk("arst_addr", int'(mem_addr), 0); chk("arst_eq", int'(is_equal), 1);
    nxt;

    // Randomized traffic
    prev_rd = 1'b0;
    prev_d  = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(199) == 0);
      reset   = ($urandom_range(39) == 0);
      preset  = ($urandom_range(39) == 0);
      en      = $urandom_range(1);
      up_down = $urandom_range(1);
      read    = ($urandom_range(2) == 0);
      write   = ($urandom_range(5) == 0);
      data    = $urandom_range(1);
      if (prev_rd && $urandom_range(1) == 1) mem_rdata = prev_d ? 8'hFF : 8'h00;
      else                                   mem_rdata = DW'($urandom);
      prev_rd = read && !write;
      prev_d  = data;
      nxt;
    end
    rst = 1'b0; reset = 1'b0; preset = 1'b0; en = 1'b0; read = 1'b0; write = 1'b0;
    nxt;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bist_addr_data_path.md
Name: bist_addr_data_path

Overview:
- Datapath stage directly beneath the memory BIST controller (mem_FSM) in the BIST top.
- Consumes the controller's reset, preset, en, up_down, read, write and data commands.
- Drives the memory-under-test address, write data and strobes.
- Returns carry (address terminal count) and is_equal (read-back compare result) to the controller, and keeps a sticky record of the first failing address.

Parameters:
- DATA_WIDTH, 8, memory word width in bits.
- AD_WIDTH, 4, address width in bits; address range 0 .. 2^AD_WIDTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- reset  input  1  sync: clear address counter to 0, clear sticky fail record.
- preset  input  1  sync: load address counter to all ones.
- en  input  1  counter step enable.
- up_down  input  1  count direction: 1 = up, 0 = down.
- read  input  1  issue a memory read at the current address.
- write  input  1  issue a memory write at the current address.
- data  input  1  background select: 0 = all-zeros word, 1 = all-ones word.
- mem_rdata  input  DATA_WIDTH  memory read data, valid one cycle after mem_re.
- mem_addr  output  AD_WIDTH  address to memory; equals the counter value.
- mem_wdata  output  DATA_WIDTH  write data, combinational: {DATA_WIDTH{data}}.
- mem_we  output  1  write strobe, combinational: write.
- mem_re  output  1  read strobe, combinational: read & ~write.
- carry  output  1  terminal count, combinational.
- is_equal  output  1  registered compare result.
- cmp_valid  output  1  one-cycle pulse, is_equal updated this cycle.
- fail_seen  output  1  sticky: a mismatch has occurred since the last clear.
- fail_addr  output  AD_WIDTH  address of the first mismatch.

Behaviour:
- rst asserted, asynchronous: counter = 0, is_equal = 1, cmp_valid = 0, fail_seen = 0, fail_addr = 0; the read pipeline is flushed.
- Counter priority per clock edge: reset > preset > en.
  - reset: counter 0.
  - preset: counter 2^AD_WIDTH-1.
  - en & up_down: counter+1, modulo 2^AD_WIDTH.
  - en & ~up_down: counter-1, modulo 2^AD_WIDTH.
  - Otherwise the counter holds.
- carry = en & ((up_down & counter == all ones) | (~up_down & counter == 0)). It is asserted in the cycle before wrap, so the controller sees the last address; the wrap still happens if en remains high.
- read & write together: the write is performed, the read is suppressed and no compare is scheduled.
- Read pipeline, read issued in cycle t at address A with data = d:
  - Stage 1, edge end of t: capture valid1 = 1, expected = {DATA_WIDTH{d}}, addr1 = A.
  - Stage 2, edge end of t+1: is_equal <= (mem_rdata == expected), cmp_valid <= 1.
  - Result is visible in cycle t+2, total latency 2.
  - Back-to-back reads every cycle are fully pipelined: one result per cycle.
- cmp_valid is low in any cycle without a completing compare. is_equal holds its last value between compares.
- On a completing compare with a mismatch and fail_seen = 0: fail_seen <= 1 and fail_addr <= addr1. Later mismatches do not overwrite fail_addr.
- reset (sync) clears fail_seen and fail_addr. It also clears valid1, dropping any in-flight compare, so cmp_valid stays 0 the next cycle. is_equal is not changed by reset.
- Counter changes do not affect an in-flight compare: its address and expected data were captured at issue.
- rst asserted mid-read: the pending compare is discarded and no cmp_valid follows release.

Test Plan:
- Assert rst, release, hold all inputs 0 for 3 cycles -> mem_addr = 0, is_equal = 1, cmp_valid = 0, fail_seen = 0 throughout.
- AD_WIDTH = 4: reset pulse, then en = 1, up_down = 1 for 17 cycles -> addresses 0..15 then 0; carry high only while addr = 15; preset then down count gives carry only at addr = 0.
- write = 1, data = 1 at addr 3; next cycle read = 1, data = 1, memory returns 8'hFF -> mem_wdata = 8'hFF, cmp_valid pulses 2 cycles after read, is_equal = 1, fail_seen stays 0.
- Reads at addr 5, 6, 7 on consecutive cycles, data = 0, memory returns 00, 04, 10 -> cmp_valid high for 3 consecutive cycles, is_equal = 1, 0, 0; fail_seen = 1, fail_addr = 6 (not 7).
- read = 1 and write = 1 in the same cycle -> mem_re = 0, mem_we = 1, no cmp_valid 2 cycles later; preset and en together -> counter = all ones.
- Issue a read, then assert reset in the following cycle -> no cmp_valid, fail_seen = 0, mem_addr = 0; repeat with rst instead -> same outcome.
